addr_region_decoder: RTL and testbench
======================================

ADDR_REGION_DECODER -- requirements
Module: addr_region_decoder

Interface
REQ-001 Parameter: ADDR_W, 13, address width in bits.
REQ-002 Parameter: NREG, 2, number of decoded regions (1..8).
REQ-003 Parameter: WS_W, 4, wait-state counter width.
REQ-004 Parameter: REGION_BASE, {13'h0000,13'h1800}, packed NREG*ADDR_W vector; region i base in slice i.
REQ-005 Parameter: REGION_MASK, {13'h0000,13'h1800}, packed NREG*ADDR_W vector; region i compare mask in slice i.
REQ-006 Parameter: REGION_WS, {4'd1,4'd0}, packed NREG*WS_W vector; region i wait states in slice i.
REQ-007 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-008 Port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-009 Port: req  input  1  access request, sampled only in IDLE.
REQ-010 Port: addr  input  ADDR_W  access address, sampled with req.
REQ-011 Port: sel  output  NREG  registered one-hot region select.
REQ-012 Port: ack  output  1  one-cycle access-complete pulse.
REQ-013 Port: err  output  1  one-cycle unmapped-access pulse.
REQ-014 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-015 Region i SHALL match when (addr & MASK_i) == (BASE_i & MASK_i); a mask of all zeros matches every address.
REQ-016 On multiple matches, the lowest index SHALL win; sel SHALL never carry more than one set bit.
REQ-017 FSM states SHALL be IDLE, SEL, ERR.
REQ-018 IDLE: req=1 at edge k SHALL register addr, the matched index and its wait-state count; next state SEL if matched, else ERR (see Configuration).
REQ-019 SEL: sel[i] SHALL be held high; the counter SHALL decrement by 1 per cycle while nonzero.
REQ-020 SEL with counter == 0: ack SHALL be 1 that cycle; next state IDLE; sel SHALL drop at the following edge.
REQ-021 Latency: ack SHALL occur WS_i+1 cycles after the accepting edge; sel SHALL be high for exactly WS_i+1 cycles.
REQ-022 ERR: err SHALL be 1 for exactly one cycle, with sel=0 and ack=0; next state IDLE.
REQ-023 req while busy=1, including the ack or err cycle, SHALL be ignored and not queued.
REQ-024 Changes of addr outside the accepting edge SHALL not affect sel, ack or counter.
REQ-025 ack and err SHALL never be high in the same cycle.
REQ-026 Wait-state values SHALL be unsigned WS_W-bit; the counter SHALL not wrap below zero.

Reset
REQ-027 rst_n=0 SHALL force IDLE, sel=0, ack=0, err=0, busy=0 and counter=0 without waiting for clk.
REQ-028 Reset asserted mid-access (SEL or ERR) SHALL abort the access; no ack or err SHALL follow release.
REQ-029 The first req SHALL be accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro ADDR_DECODE_ERR_EN defined: an unmapped address SHALL take IDLE->ERR and pulse err.
REQ-031 Macro ADDR_DECODE_ERR_EN undefined: an unmapped address SHALL select region NREG-1 with its wait states, err SHALL be tied 0, and ERR SHALL be absent.

Verification
REQ-032 Defaults, req with addr=13'h1804 -> sel=2'b01 for 1 cycle; ack in the same cycle, 1 cycle after accept.
REQ-033 Defaults, req with addr=13'h0100 -> sel=2'b10 for 2 cycles; ack in the 2nd cycle; busy high for 2 cycles.
REQ-034 Defaults, req with addr=13'h1000 (REGION_1 mask catch-all) -> sel=2'b10, not 2'b01; err stays 0.
REQ-035 ERR_EN defined, NREG=2, both masks 13'h1800, bases 13'h1800 and 13'h0800; addr=13'h0000 -> err pulse 1 cycle, sel=0, no ack; with the macro undefined -> sel=2'b10, ack.
REQ-036 req held high continuously with addr=13'h0100 -> accepts spaced 3 cycles apart (2 SEL + 1 IDLE); no back-to-back ack.
REQ-037 rst_n pulsed low in the 1st SEL cycle of a 13'h0100 access -> sel=0 immediately; no ack after release.

Source files
------------

// File: rtl/addr_region_decoder.sv
// Address region decoder: one-hot registered select with per-region wait states.
// Optional ADDR_DECODE_ERR_EN: unmapped accesses pulse err instead of falling back to region NREG-1.

module addr_region_match #(
  parameter int                ADDR_W = 13,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W-1:0] MASK   = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit
);
  assign hit = ((addr & MASK) == (BASE & MASK));
endmodule

module addr_region_decoder #(
  parameter int                     ADDR_W      = 13,
  parameter int                     NREG        = 2,
  parameter int                     WS_W        = 4,
  parameter logic [NREG*ADDR_W-1:0] REGION_BASE = {13'h0000, 13'h1800},
  parameter logic [NREG*ADDR_W-1:0] REGION_MASK = {13'h0000, 13'h1800},
  parameter logic [NREG*WS_W-1:0]   REGION_WS   = {4'd1, 4'd0}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [NREG-1:0]   sel,
  output logic              ack,
  output logic              err,
  output logic              busy
);
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

`ifdef ADDR_DECODE_ERR_EN
  typedef enum logic [1:0] {S_IDLE, S_SEL, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEL} state_t;
`endif

  state_t                      state, state_d;
  logic [NREG-1:0]             hit;
  logic [NREG-1:0][WS_W-1:0]   ws_tab;
  logic [IDX_W-1:0]            hit_idx;
  logic [NREG-1:0]             sel_hot;
  logic [NREG-1:0]             sel_q, sel_d;
  logic [WS_W-1:0]             cnt, cnt_d;

  assign ws_tab = REGION_WS;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    addr_region_match #(
      .ADDR_W (ADDR_W),
      .BASE   (REGION_BASE[g*ADDR_W +: ADDR_W]),
      .MASK   (REGION_MASK[g*ADDR_W +: ADDR_W])
    ) u_match (
      .addr (addr),
      .hit  (hit[g])
    );
  end

  // Scan downward so the lowest matching index wins; no match leaves NREG-1.
  always_comb begin
    hit_idx = IDX_W'(NREG - 1);
    for (int i = NREG - 1; i >= 0; i--)
      if (hit[i]) hit_idx = IDX_W'(i);
  end

  always_comb begin
    sel_hot = '0;
    for (int i = 0; i < NREG; i++)
      sel_hot[i] = (hit_idx == IDX_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sel_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      sel_q <= sel_d;
      cnt   <= cnt_d;
    end
  end

`ifdef ADDR_DECODE_ERR_EN
  logic hit_any;
  assign hit_any = |hit;
`endif

  always_comb begin
    state_d = state;
    sel_d   = sel_q;
    cnt_d   = cnt;
    ack     = 1'b0;
`ifdef ADDR_DECODE_ERR_EN
    err     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (req) begin
`ifdef ADDR_DECODE_ERR_EN
          if (!hit_any) begin
            state_d = S_ERR;
          end else begin
`else
          begin
`endif
            state_d = S_SEL;
            sel_d   = sel_hot;
            cnt_d   = ws_tab[hit_idx];
          end
        end
      end
      S_SEL: begin
        if (cnt == '0) begin
          ack     = 1'b1;
          state_d = S_IDLE;
          sel_d   = '0;
        end else begin
          cnt_d = cnt - WS_W'(1);
        end
      end
`ifdef ADDR_DECODE_ERR_EN
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

`ifndef ADDR_DECODE_ERR_EN
  assign err = 1'b0;
`endif

  assign sel  = sel_q;
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_addr_region_decoder.sv
// Scoreboard bench for addr_region_decoder: stimulus pushes expectations, a monitor pops them on ack.
module tb_addr_region_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [12:0] addr = '0;
  logic [1:0]  sel;
  logic        ack, err, busy;

  logic        req2 = 1'b0;
  logic [12:0] addr2 = '0;
  logic [1:0]  sel2;
  logic        ack2, err2, busy2;

  always #5 clk = ~clk;

  addr_region_decoder dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr),
    .sel(sel), .ack(ack), .err(err), .busy(busy)
  );

  // Two narrow regions with a hole at 13'h0000 for the unmapped path.
  addr_region_decoder #(
    .REGION_BASE({13'h0800, 13'h1800}),
    .REGION_MASK({13'h1800, 13'h1800})
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .addr(addr2),
    .sel(sel2), .ack(ack2), .err(err2), .busy(busy2)
  );

  typedef struct {
    logic [1:0] sel;
    int         nsel;
  } exp_t;

  exp_t exp_q[$];
  int   ack_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // Monitor: counts sel-high cycles, checks each ack against the queue head.
  initial begin
    int   sel_cycles;
    exp_t e;
    sel_cycles = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sel_cycles = 0;
      end else begin
        if (sel != 2'b00) sel_cycles++;
        if (ack && err) chk("ack_err_excl", 1, 0);
        if (ack) begin
          ack_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sel_at_ack", 32'(sel), 32'(e.sel));
            chk("sel_cycles", sel_cycles, e.nsel);
            chk("busy_at_ack", 32'(busy), 1);
            chk("err_at_ack", 32'(err), 0);
          end
          sel_cycles = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("idle_timeout", 1, 0);
  endtask

  task automatic access(input logic [12:0] a, input logic [1:0] es, input int en);
    exp_t e;
    @(negedge clk);
    addr = a;
    req  = 1'b1;
    e.sel = es; e.nsel = en;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req  = 1'b0;
    addr = a ^ 13'h1fff;
    chk("accept_busy", 32'(busy), 1);
    wait_idle();
  endtask

  task automatic dut2_access(input logic [12:0] a, input logic [1:0] es, input int en,
                             input int eack, input int eerr);
    logic [1:0] seen;
    int nsel, nack, nerr;
    seen = '0; nsel = 0; nack = 0; nerr = 0;
    @(negedge clk);
    addr2 = a;
    req2  = 1'b1;
    @(posedge clk);
    #1;
    req2  = 1'b0;
    addr2 = 13'h0abc;
    repeat (6) begin
      @(negedge clk);
      if (sel2 != 2'b00) begin
        nsel++;
        seen |= sel2;
      end
      nack += int'(ack2);
      nerr += int'(err2);
    end
    chk("dut2_sel", 32'(seen), 32'(es));
    chk("dut2_sel_cycles", nsel, en);
    chk("dut2_acks", nack, eack);
    chk("dut2_errs", nerr, eerr);
  endtask

  initial begin
    int n0;
    exp_t e;

    // Reset state before any clock edge
    #3;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // First req right after release; region 0, zero wait states
    access(13'h1804, 2'b01, 1);
    // Region 1 fallback, one wait state
    access(13'h0100, 2'b10, 2);
    // Misses region 0 mask, caught by region 1
    access(13'h1000, 2'b10, 2);
    access(13'h1fff, 2'b01, 1);

    // req asserted during SEL and the ack cycle is ignored
    n0 = ack_cyc.size();
    @(negedge clk);
    addr = 13'h0100; req = 1'b1;
    e.sel = 2'b10; e.nsel = 2;
    exp_q.push_back(e);
    @(posedge clk);
    #1 addr = 13'h1804;
    @(posedge clk);
    @(posedge clk);
    #1 req = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("busy_req_ignored", ack_cyc.size() - n0, 1);

    // Continuous req: accepts every 3 cycles
    n0 = ack_cyc.size();
    @(negedge clk);
    addr = 13'h0100; req = 1'b1;
    e.sel = 2'b10; e.nsel = 2;
    repeat (3) exp_q.push_back(e);
    repeat (7) @(posedge clk);
    #1 req = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("cont_ack_count", ack_cyc.size() - n0, 3);
    if (ack_cyc.size() >= n0 + 3) begin
      chk("cont_spacing_1", ack_cyc[n0+1] - ack_cyc[n0], 3);
      chk("cont_spacing_2", ack_cyc[n0+2] - ack_cyc[n0+1], 3);
    end

    // Reset in first SEL cycle aborts the access
    n0 = ack_cyc.size();
    @(negedge clk);
    addr = 13'h0100; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    chk("abort_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_sel", 32'(sel), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ack", 32'(ack), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_ack", ack_cyc.size() - n0, 0);

    // Access accepted again after the abort
    access(13'h1804, 2'b01, 1);

    // Narrow-region instance: mapped hit, then the unmapped hole
    dut2_access(13'h1804, 2'b01, 1, 1, 0);
`ifdef ADDR_DECODE_ERR_EN
    dut2_access(13'h0000, 2'b00, 0, 0, 1);
`else
    dut2_access(13'h0000, 2'b10, 2, 1, 0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
